// File: rtl/sms_cmd_pkg.sv
// sms_cmd_pkg: ASCII constants and parser state shared by the SMS command dispatcher
package sms_cmd_pkg;
    localparam logic [7:0] ST_CHR   = 8'h2A;
    localparam logic [7:0] END_CHR  = 8'h23;
    localparam logic [7:0] OP_ON    = 8'h4E;
    localparam logic [7:0] OP_OFF   = 8'h46;
    localparam logic [7:0] OP_TGL   = 8'h54;
    localparam logic [7:0] OP_STS   = 8'h53;
    localparam logic [7:0] ERR_CHR  = 8'h45;
    localparam logic [7:0] CTRL_Z   = 8'h1A;
    localparam logic [7:0] ZERO_CHR = 8'h30;
    localparam logic [7:0] ONE_CHR  = 8'h31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAN,
        S_OP,
        S_TERM,
        S_APPLY,
        S_REPLY,
        S_ERR,
        S_EREPLY
    } state_e;
endpackage

// File: rtl/sms_cmd_dispatch_if.sv
// sms_cmd_dispatch_if: byte-stream in from the parser, reply stream out to the SMS transmitter
interface sms_cmd_dispatch_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/sms_reply_ser.sv
// sms_reply_ser: serialises a status vector ('0'/'1' per channel) or an error reply, each ending in Ctrl-Z
module sms_reply_ser
    import sms_cmd_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_err,
    input  logic [NUM_CH-1:0] status,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              done
);
    localparam int IW = $clog2(NUM_CH + 1);

    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] vec_q, vec_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic              last, fire;

    function automatic logic [7:0] byte_at(input logic [IW-1:0] i, input logic [NUM_CH-1:0] v,
                                           input logic e);
        logic [NUM_CH-1:0] sh;
        sh = v >> i;
        if (e) return (i == '0) ? ERR_CHR : CTRL_Z;
        if (int'(i) >= NUM_CH) return CTRL_Z;
        return sh[0] ? ONE_CHR : ZERO_CHR;
    endfunction

    assign last     = err_q ? (idx_q == IW'(1)) : (idx_q == IW'(NUM_CH));
    assign fire     = valid_q && tx_ready;
    assign done     = fire && last;
    assign tx_valid = valid_q;
    assign tx_data  = data_q;

    // Load a new reply on start; advance to the next byte the cycle after each handshake
    always_comb begin
        vec_d   = vec_q;
        err_d   = err_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (start) begin
            vec_d   = status;
            err_d   = start_err;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = byte_at('0, status, start_err);
        end else if (fire) begin
            valid_d = !last;
            idx_d   = last ? idx_q : idx_q + 1'b1;
            data_d  = last ? data_q : byte_at(idx_d, vec_q, err_q);
        end
    end

    // Reply state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q   <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            vec_q   <= vec_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/sms_cmd_dispatch.sv
// sms_cmd_dispatch: parses *<ch><op># frames, drives motor channels and streams an ASCII reply
module sms_cmd_dispatch
    import sms_cmd_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TOUT_CYC = 50_000_000,
    parameter int TOUT_W   = $clog2(TOUT_CYC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    sms_cmd_dispatch_if.slave  bus,
    output logic [NUM_CH-1:0]  motor_status,
    output logic               load,
    output logic [7:0]         err_cnt
);
    localparam logic [7:0] MAX_DIG = 8'(int'(ZERO_CHR) + NUM_CH);

    state_e            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic [7:0]        op_q, op_d;
    logic [NUM_CH-1:0] motor_q, motor_d, sel;
    logic              load_q, load_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic              kick_q, kick_d;
    logic              acc, is_star, is_end, ch_ok, op_ok, timing, tout_hit, err_go, ser_done;

    assign bus.rx_ready = !(state_q inside {S_APPLY, S_REPLY, S_EREPLY});
    assign acc          = bus.rx_valid && bus.rx_ready;
    assign is_star      = bus.rx_data == ST_CHR;
    assign is_end       = bus.rx_data == END_CHR;
    assign ch_ok        = bus.rx_data >= ONE_CHR && bus.rx_data <= MAX_DIG;
    assign op_ok        = bus.rx_data inside {OP_ON, OP_OFF, OP_TGL, OP_STS};
    assign timing       = state_q inside {S_CHAN, S_OP, S_TERM, S_ERR};
    assign tout_hit     = timing && tout_q == TOUT_W'(TOUT_CYC);
    assign err_go       = state_q == S_ERR && acc && is_end;
    assign sel          = NUM_CH'(1) << ch_q;
    assign motor_status = motor_q;
    assign load         = load_q;
    assign err_cnt      = err_cnt_q;

    // Frame parser: a '*' anywhere inside a frame restarts it; a stalled frame times out silently
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = (acc && is_star) ? S_CHAN : S_IDLE;
            S_CHAN: begin
                if (acc) state_d = is_star ? S_CHAN : ch_ok ? S_OP : S_ERR;
                if (acc && ch_ok) ch_d = bus.rx_data[3:0] - 4'd1;
            end
            S_OP: begin
                if (acc) state_d = is_star ? S_CHAN : op_ok ? S_TERM : S_ERR;
                if (acc && op_ok) op_d = bus.rx_data;
            end
            S_TERM:   if (acc) state_d = is_star ? S_CHAN : is_end ? S_APPLY : S_ERR;
            S_ERR:    if (acc) state_d = is_star ? S_CHAN : is_end ? S_EREPLY : S_ERR;
            S_APPLY:  state_d = S_REPLY;
            S_REPLY,
            S_EREPLY: state_d = ser_done ? S_IDLE : state_q;
            default:  state_d = S_IDLE;
        endcase
        if (tout_hit && !acc) state_d = S_IDLE;
    end

    // Channel bank update, load pulse, error counter, timeout counter and reply kick-off
    always_comb begin
        load_d    = state_q == S_APPLY && op_q != OP_STS;
        motor_d   = !load_d ? motor_q :
                    op_q == OP_ON  ? motor_q | sel :
                    op_q == OP_OFF ? motor_q & ~sel : motor_q ^ sel;
        err_cnt_d = (err_go && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        tout_d    = (timing && !acc) ? tout_q + 1'b1 : '0;
        kick_d    = state_q == S_APPLY;
    end

    // Dispatcher registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            op_q      <= '0;
            motor_q   <= '0;
            load_q    <= 1'b0;
            err_cnt_q <= '0;
            tout_q    <= '0;
            kick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            op_q      <= op_d;
            motor_q   <= motor_d;
            load_q    <= load_d;
            err_cnt_q <= err_cnt_d;
            tout_q    <= tout_d;
            kick_q    <= kick_d;
        end
    end

    sms_reply_ser #(.NUM_CH(NUM_CH)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .start     (kick_q || err_go),
        .start_err (err_go),
        .status    (motor_q),
        .tx_ready  (bus.tx_ready),
        .tx_valid  (bus.tx_valid),
        .tx_data   (bus.tx_data),
        .done      (ser_done)
    );
endmodule

// File: tb/tb_sms_cmd_dispatch.sv
// tb_sms_cmd_dispatch: directed frames with a reply scoreboard for the SMS command dispatcher
module tb_sms_cmd_dispatch;
    localparam int NUM_CH   = 4;
    localparam int TOUT_CYC = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] motor_status;
    logic       load;
    logic [7:0] err_cnt;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [3:0] m_motor = '0;
    logic [7:0] m_err = '0;

    sms_cmd_dispatch_if bus ();

    sms_cmd_dispatch #(.NUM_CH(NUM_CH), .TOUT_CYC(TOUT_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .motor_status (motor_status),
        .load         (load),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_accept", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_status();
        for (int i = 0; i < NUM_CH; i++) exp_q.push_back(m_motor[i] ? 8'h31 : 8'h30);
        exp_q.push_back(8'h1A);
    endtask

    task automatic drain(input int stall_at, input int abort_at);
        int k = 0;
        int guard = 0;
        logic [7:0] e;
        bus.tx_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 200) begin
            if (bus.tx_valid === 1'b1) begin
                e = exp_q.pop_front();
                if (k == stall_at) begin
                    bus.tx_ready = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        chk("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
                        chk("stall_tx_data", 32'(bus.tx_data), 32'(e));
                        chk("stall_rx_ready", 32'(bus.rx_ready), 32'd0);
                    end
                    bus.tx_ready = 1'b1;
                end
                chk($sformatf("reply_byte%0d", k), 32'(bus.tx_data), 32'(e));
                if (k == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    m_motor = '0;
                    m_err   = '0;
                    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
                    chk("rst_motor", 32'(motor_status), 32'(m_motor));
                    chk("rst_err_cnt", 32'(err_cnt), 32'(m_err));
                    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
                    return;
                end
                k++;
            end
            @(negedge clk);
            guard++;
        end
        chk("reply_remaining", 32'(exp_q.size()), 32'd0);
        chk("post_reply_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("post_reply_rx_ready", 32'(bus.rx_ready), 32'd1);
    endtask

    task automatic cmd(input logic [7:0] ch, input logic [7:0] op, input int stall_at, input int abort_at);
        logic       ok;
        logic [3:0] s;
        ok = ch >= 8'h31 && ch <= 8'h34 && op inside {8'h4E, 8'h46, 8'h54, 8'h53};
        if (ok) begin
            s = 4'b0001 << (ch - 8'h31);
            if (op == 8'h4E) m_motor = m_motor | s;
            if (op == 8'h46) m_motor = m_motor & ~s;
            if (op == 8'h54) m_motor = m_motor ^ s;
            push_status();
        end else begin
            exp_q.push_back(8'h45);
            exp_q.push_back(8'h1A);
            if (m_err != 8'hFF) m_err++;
        end
        send_byte(8'h2A);
        send_byte(ch);
        send_byte(op);
        send_byte(8'h23);
        if (ok) begin
            @(negedge clk);
            chk("load_pulse", 32'(load), 32'(op != 8'h53));
            chk("motor_after_apply", 32'(motor_status), 32'(m_motor));
            chk("tx_idle_in_apply", 32'(bus.tx_valid), 32'd0);
        end else begin
            chk("err_first_byte_valid", 32'(bus.tx_valid), 32'd1);
            chk("err_cnt", 32'(err_cnt), 32'(m_err));
            chk("err_no_load", 32'(load), 32'd0);
            chk("err_motor", 32'(motor_status), 32'(m_motor));
        end
        drain(stall_at, abort_at);
    endtask

    initial begin
        int n;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_motor", 32'(motor_status), 32'd0);
        chk("reset_load", 32'(load), 32'd0);
        chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("reset_tx_data", 32'(bus.tx_data), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        chk("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        cmd(8'h32, 8'h4E, -1, -1);
        cmd(8'h34, 8'h4E, -1, -1);
        chk("status_1010", 32'(motor_status), 32'hA);
        cmd(8'h32, 8'h54, -1, -1);
        cmd(8'h33, 8'h53, -1, -1);
        chk("status_1000", 32'(motor_status), 32'h8);

        cmd(8'h35, 8'h4E, -1, -1);
        cmd(8'h30, 8'h46, -1, -1);
        chk("err_cnt_two", 32'(err_cnt), 32'd2);

        send_byte(8'h2A);
        send_byte(8'h31);
        repeat (TOUT_CYC + 5) @(negedge clk);
        send_byte(8'h4E);
        send_byte(8'h23);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_valid === 1'b1) n++;
        end
        chk("tout_no_reply", 32'(n), 32'd0);
        chk("tout_motor", 32'(motor_status), 32'(m_motor));
        chk("tout_err_cnt", 32'(err_cnt), 32'(m_err));

        push_status();
        send_byte(8'h2A);
        send_byte(8'h33);
        repeat (TOUT_CYC - 10) @(negedge clk);
        send_byte(8'h53);
        send_byte(8'h23);
        drain(-1, -1);

        cmd(8'h31, 8'h4E, -1, -1);
        chk("bit0_set", 32'(motor_status), 32'h9);

        m_motor = m_motor ^ 4'b0100;
        push_status();
        send_byte(8'h2A);
        send_byte(8'h32);
        send_byte(8'h2A);
        send_byte(8'h33);
        send_byte(8'h54);
        send_byte(8'h23);
        drain(-1, -1);
        chk("restart_motor", 32'(motor_status), 32'hD);
        chk("restart_err_cnt", 32'(err_cnt), 32'd2);

        cmd(8'h31, 8'h6E, -1, -1);
        cmd(8'h33, 8'h46, 1, -1);
        cmd(8'h32, 8'h4E, -1, 2);
        cmd(8'h31, 8'h46, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
